sdpram_byte_pipe: RTL

- Second-generation simple dual-port RAM: one write port (A) and one read port (B) on a single clock.
- Adds per-byte write strobes, a selectable read latency of 1 or 2 cycles, a defined read-during-write policy and a collision flag.
- Used as the generic storage primitive behind FIFOs, packet buffers and lookup tables. Memory infers as block RAM.

---
 rtl/sdpram_byte_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sdpram_byte_pipe.sv
// Simple dual-port RAM: one byte-strobed write port, one read port with 1- or 2-cycle
// registered latency, selectable read-during-write policy and a collision flag.
module sdpram_byte_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int BYTE_WRITE   = 1,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH),
  localparam int STRB_WIDTH  = (BYTE_WRITE != 0) ? DATA_WIDTH / 8 : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [STRB_WIDTH-1:0] wena,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic                  renb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  dvalb,
  output logic                  collb
);

  localparam int LANE_W = (BYTE_WRITE != 0) ? 8 : DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
    $error("sdpram_byte_pipe: READ_LATENCY must be 1 or 2");
  end
  if (BYTE_WRITE != 0 && (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("sdpram_byte_pipe: DATA_WIDTH must be a multiple of 8 with BYTE_WRITE=1");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  coll;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_val;

  assign wr_in_range = {1'b0, addra} < DEPTH_L;
  assign rd_in_range = {1'b0, addrb} < DEPTH_L;
  assign coll        = renb && (|wena) && wr_in_range && rd_in_range && (addra == addrb);
  assign rd_word     = mem[addrb];

  // Write-first view of the addressed word: new bytes on strobed lanes, old bytes elsewhere.
  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
    assign merged_word[gi*LANE_W +: LANE_W] =
      wena[gi] ? dina[gi*LANE_W +: LANE_W] : rd_word[gi*LANE_W +: LANE_W];
  end

  always_comb begin
    rd_val = rd_word;
    if (!rd_in_range)
      rd_val = '0;
    else if (RDW_MODE == 1 && coll)
      rd_val = merged_word;
  end

  // Storage has no reset so it maps onto block RAM; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_in_range) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wena[i])
          mem[addra][i*LANE_W +: LANE_W] <= dina[i*LANE_W +: LANE_W];
      end
    end
  end

  logic                  out_v_d;
  logic                  out_coll_d;
  logic [DATA_WIDTH-1:0] out_data_d;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_v_q;
    logic                  s1_coll_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_v_q    <= 1'b0;
        s1_coll_q <= 1'b0;
      end else begin
        s1_v_q    <= renb;
        s1_coll_q <= coll;
      end
    end

    always_ff @(posedge clk) begin
      if (renb)
        s1_data_q <= rd_val;
    end

    assign out_v_d    = s1_v_q;
    assign out_coll_d = s1_coll_q;
    assign out_data_d = s1_data_q;
  end else begin : g_lat1
    assign out_v_d    = renb;
    assign out_coll_d = coll;
    assign out_data_d = rd_val;
  end

  logic                  dvalb_q;
  logic                  collb_q;
  logic [DATA_WIDTH-1:0] doutb_q;

  // Output word only moves on a valid beat, so it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvalb_q <= 1'b0;
      collb_q <= 1'b0;
      doutb_q <= '0;
    end else begin
      dvalb_q <= out_v_d;
      collb_q <= out_v_d && out_coll_d;
      if (out_v_d)
        doutb_q <= out_data_d;
    end
  end

  assign doutb = doutb_q;
  assign dvalb = dvalb_q;
  assign collb = collb_q;

endmodule
